fetch_unit: RTL

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, drives the instruction memory address, captures the returned word into the IF/ID pipeline register, and applies stall, flush and branch/jump redirect requests from downstream stages. It detects the instruction memory's unmapped-address pattern (32'hFFFF_FFFF) and misaligned redirect targets, and halts fetch on either fault.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, downstream control requests,
// the IF/ID register outputs and fault status.
interface fetch_unit_if;
    logic [31:0] Address;
    logic [31:0] Word;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] IfId_Instr;
    logic [31:0] IfId_PC;
    logic [31:0] IfId_PCPlus4;
    logic        IfId_Valid;
    logic        Fault;
    logic [31:0] FaultPC;
    logic [31:0] FetchCount;

    // Fetch unit side: masters the instruction memory address.
    modport master (
        output Address, IfId_Instr, IfId_PC, IfId_PCPlus4, IfId_Valid,
               Fault, FaultPC, FetchCount,
        input  Word, Stall, Flush, Redirect, RedirectTarget
    );

    // Environment side: memory plus downstream pipeline control.
    modport slave (
        input  Address, IfId_Instr, IfId_PC, IfId_PCPlus4, IfId_Valid,
               Fault, FaultPC, FetchCount,
        output Word, Stall, Flush, Redirect, RedirectTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID capture, stall/flush/redirect
// handling, and halt-on-fault for unmapped fetches or misaligned targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    // Instruction memory drives all-ones for unmapped addresses.
    localparam logic [31:0] UnmappedWord = 32'hFFFF_FFFF;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_pc4_q;
    logic        valid_q;
    logic        fault_q;
    logic [31:0] fault_pc_q;
    logic [31:0] count_q;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // All outputs come straight from registers; nothing combinational from inputs.
    assign bus.Address      = pc_q;
    assign bus.IfId_Instr   = instr_q;
    assign bus.IfId_PC      = ifid_pc_q;
    assign bus.IfId_PCPlus4 = ifid_pc4_q;
    assign bus.IfId_Valid   = valid_q;
    assign bus.Fault        = fault_q;
    assign bus.FaultPC      = fault_pc_q;
    assign bus.FetchCount   = count_q;

    // Fetch FSM: Redirect > Stall > fault check > normal fetch; HALT is terminal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            ifid_pc_q  <= '0;
            ifid_pc4_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.Redirect) begin
                        valid_q <= 1'b0;
                        if (bus.RedirectTarget[1:0] != 2'b00) begin
                            state_q    <= StHalt;
                            fault_q    <= 1'b1;
                            fault_pc_q <= bus.RedirectTarget;
                        end else begin
                            // Wrong-path word is dropped; IF/ID data left as is.
                            pc_q <= bus.RedirectTarget;
                        end
                    end else if (bus.Stall) begin
                        if (bus.Flush) begin
                            valid_q <= 1'b0;
                        end
                    end else if (bus.Word == UnmappedWord) begin
                        state_q    <= StHalt;
                        fault_q    <= 1'b1;
                        fault_pc_q <= pc_q;
                        valid_q    <= 1'b0;
                    end else begin
                        pc_q       <= pc_plus4;
                        instr_q    <= bus.Word;
                        ifid_pc_q  <= pc_q;
                        ifid_pc4_q <= pc_plus4;
                        valid_q    <= !bus.Flush;
                        if (!bus.Flush) begin
                            count_q <= count_q + 32'd1;
                        end
                    end
                end
                StHalt: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StHalt;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
